// File: rtl/uart_rx_if.sv
// Signal bundle between a serial-line / baud-tick source (master) and the uart_rx receiver (slave).
interface uart_rx_if;
  logic       BAUD_CLK;
  logic       RXD;
  logic [7:0] DATA;
  logic       DATA_VALID;
  logic       FRAME_ERR;
  logic       PAR_ERR;
  logic       BUSY;

  modport master (
    output BAUD_CLK, RXD,
    input  DATA, DATA_VALID, FRAME_ERR, PAR_ERR, BUSY
  );

  modport slave (
    input  BAUD_CLK, RXD,
    output DATA, DATA_VALID, FRAME_ERR, PAR_ERR, BUSY
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation, LSB-first data, optional parity, stop check.
// Define UART_RX_PARITY_EN to add one parity bit per frame, checked according to PARITY_ODD.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic      SCLK,
  input logic      SCLR,
  uart_rx_if.slave bus
);
  localparam int unsigned      SctrW    = $clog2(OVERSAMPLE);
  localparam logic [SctrW-1:0] SctrMid  = SctrW'(OVERSAMPLE / 2 - 1);
  localparam logic [SctrW-1:0] SctrLast = SctrW'(OVERSAMPLE - 1);
  localparam logic [3:0]       BctrLast = 4'(DATA_BITS - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx: illegal parameter combination");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

  state_e                 state_q, state_d;
  logic                   rxd_meta_q, rxd_s_q;
  logic [SctrW-1:0]       sctr_q, sctr_d;
  logic [3:0]             bctr_q, bctr_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [7:0]             data_q, data_d;
  logic                   dv_q, dv_d;
  logic                   fe_q, fe_d;

  always_ff @(posedge SCLK) begin
    if (SCLR) begin
      state_q    <= StIdle;
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      sctr_q     <= '0;
      bctr_q     <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_meta_q <= bus.RXD;
      rxd_s_q    <= rxd_meta_q;
      sctr_q     <= sctr_d;
      bctr_q     <= bctr_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      fe_q       <= fe_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_rec_q, perr_rec_d;
  logic pe_q, pe_d;

  always_ff @(posedge SCLK) begin
    if (SCLR) begin
      perr_rec_q <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      perr_rec_q <= perr_rec_d;
      pe_q       <= pe_d;
    end
  end

  assign bus.PAR_ERR = pe_q;
`else
  assign bus.PAR_ERR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sctr_d  = sctr_q;
    bctr_d  = bctr_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_rec_d = perr_rec_q;
    pe_d       = 1'b0;
`endif
    if (bus.BAUD_CLK) begin
      unique case (state_q)
        StIdle: begin
          if (!rxd_s_q) begin
            state_d = StStart;
            sctr_d  = '0;
          end
        end
        StStart: begin
          // Line high again at mid start bit means a glitch, not a frame.
          if (sctr_q == SctrMid) begin
            sctr_d  = '0;
            bctr_d  = '0;
            state_d = rxd_s_q ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
            perr_rec_d = 1'b0;
`endif
          end else begin
            sctr_d = sctr_q + SctrW'(1);
          end
        end
        StData: begin
          if (sctr_q == SctrLast) begin
            sctr_d  = '0;
            shreg_d = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
            bctr_d  = bctr_q + 4'd1;
            if (bctr_q == BctrLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end else begin
            sctr_d = sctr_q + SctrW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (sctr_q == SctrLast) begin
            sctr_d     = '0;
            perr_rec_d = ((^shreg_q) ^ rxd_s_q) != PARITY_ODD[0];
            state_d    = StStop;
          end else begin
            sctr_d = sctr_q + SctrW'(1);
          end
        end
`endif
        StStop: begin
          if (sctr_q == SctrLast) begin
            sctr_d = '0;
            if (rxd_s_q) begin
              data_d  = 8'(shreg_q);
              dv_d    = 1'b1;
              state_d = StIdle;
`ifdef UART_RX_PARITY_EN
              pe_d = perr_rec_q;
`endif
            end else begin
              fe_d    = 1'b1;
              state_d = StBreak;
            end
          end else begin
            sctr_d = sctr_q + SctrW'(1);
          end
        end
        StBreak: begin
          if (rxd_s_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.DATA       = data_q;
  assign bus.DATA_VALID = dv_q;
  assign bus.FRAME_ERR  = fe_q;
  assign bus.BUSY       = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;
  localparam int unsigned Os      = 16;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned BitCyc  = Os * TickDiv;
  localparam int unsigned ParOdd  = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit          ParEn   = 1'b1;
`else
  localparam bit          ParEn   = 1'b0;
`endif

  logic SCLK;
  logic SCLR;
  uart_rx_if bus ();

  uart_rx #(
    .OVERSAMPLE(Os),
    .DATA_BITS (8),
    .PARITY_ODD(ParOdd)
  ) dut (
    .SCLK(SCLK),
    .SCLR(SCLR),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, pe_dv_cnt = 0, both_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_data;

  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  initial begin
    int div;
    div = 0;
    bus.BAUD_CLK = 1'b0;
    forever begin
      @(negedge SCLK);
      div = (div == TickDiv - 1) ? 0 : div + 1;
      bus.BAUD_CLK = (div == 0);
    end
  end

  // Pulse monitor: every cycle a pulse is high counts once, so stretched pulses show up.
  initial begin
    forever begin
      @(posedge SCLK);
      #1;
      if (bus.DATA_VALID === 1'b1) begin
        dv_cnt++;
        got_q.push_back(bus.DATA);
        if (bus.PAR_ERR === 1'b1) pe_dv_cnt++;
      end
      if (bus.FRAME_ERR === 1'b1) fe_cnt++;
      if (bus.PAR_ERR === 1'b1) pe_cnt++;
      if (bus.DATA_VALID === 1'b1 && bus.FRAME_ERR === 1'b1) both_cnt++;
    end
  end

  function automatic logic good_par(input logic [7:0] b);
    return (^b) ^ ParOdd[0];
  endfunction

  function automatic logic [7:0] pop_got();
    if (got_q.size() == 0) return 8'hxx;
    return got_q.pop_front();
  endfunction

  task automatic send_bit(input logic b);
    bus.RXD = b;
    repeat (BitCyc) @(negedge SCLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (ParEn) send_bit(par);
    send_bit(stop);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.BUSY === 1'b0) break;
      @(negedge SCLK);
    end
  endtask

  task automatic test_reset();
    SCLR = 1'b1;
    bus.RXD = 1'b1;
    repeat (5) @(negedge SCLK);
    checks += 5;
    if (bus.DATA !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 00", bus.DATA); end
    if (bus.DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", bus.DATA_VALID); end
    if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", bus.FRAME_ERR); end
    if (bus.PAR_ERR !== 1'b0) begin errors++; $display("FAIL reset_pe got %b want 0", bus.PAR_ERR); end
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
    SCLR = 1'b0;
    exp_data = 8'h00;
    repeat (2 * BitCyc) @(negedge SCLK);
  endtask

  task automatic test_basic();
    int dv0, fe0, pe0;
    logic [7:0] g;
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    send_bit(1'b1);
    wait_idle(4 * BitCyc);
    exp_data = 8'hA5;
    g = pop_got();
    checks += 6;
    if (dv_cnt - dv0 != 1) begin errors++; $display("FAIL basic_dv_count got %0d want 1", dv_cnt - dv0); end
    if (g !== 8'hA5) begin errors++; $display("FAIL basic_dv_data got %0h want a5", g); end
    if (bus.DATA !== exp_data) begin errors++; $display("FAIL basic_data got %0h want %0h", bus.DATA, exp_data); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL basic_fe got %0d want 0", fe_cnt - fe0); end
    if (pe_cnt != pe0) begin errors++; $display("FAIL basic_pe got %0d want 0", pe_cnt - pe0); end
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", bus.BUSY); end
  endtask

  task automatic test_glitch();
    int dv0, fe0;
    logic [7:0] g;
    dv0 = dv_cnt; fe0 = fe_cnt;
    bus.RXD = 1'b0;
    repeat (4 * TickDiv) @(negedge SCLK);
    bus.RXD = 1'b1;
    repeat (2 * BitCyc) @(negedge SCLK);
    checks += 3;
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", bus.BUSY); end
    if (dv_cnt != dv0) begin errors++; $display("FAIL glitch_dv got %0d want 0", dv_cnt - dv0); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_fe got %0d want 0", fe_cnt - fe0); end
    send_frame(8'h3C, good_par(8'h3C), 1'b1);
    send_bit(1'b1);
    wait_idle(4 * BitCyc);
    exp_data = 8'h3C;
    g = pop_got();
    checks += 2;
    if (dv_cnt - dv0 != 1) begin errors++; $display("FAIL glitch_next_dv got %0d want 1", dv_cnt - dv0); end
    if (g !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got %0h want 3c", g); end
  endtask

  task automatic test_frame_err();
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h81, good_par(8'h81), 1'b0);
    repeat (40 * TickDiv) @(negedge SCLK);
    checks += 4;
    if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL ferr_busy_low got %b want 1", bus.BUSY); end
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_count got %0d want 1", fe_cnt - fe0); end
    if (dv_cnt != dv0) begin errors++; $display("FAIL ferr_dv got %0d want 0", dv_cnt - dv0); end
    if (bus.DATA !== exp_data) begin errors++; $display("FAIL ferr_data got %0h want %0h", bus.DATA, exp_data); end
    bus.RXD = 1'b1;
    wait_idle(4 * BitCyc);
    repeat (BitCyc) @(negedge SCLK);
    checks += 3;
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL ferr_release_busy got %b want 0", bus.BUSY); end
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_release_fe got %0d want 1", fe_cnt - fe0); end
    if (dv_cnt != dv0) begin errors++; $display("FAIL ferr_release_dv got %0d want 0", dv_cnt - dv0); end
  endtask

  task automatic test_back_to_back();
    int dv0, fe0;
    logic [7:0] g0, g1;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h00, good_par(8'h00), 1'b1);
    send_frame(8'hFF, good_par(8'hFF), 1'b1);
    send_bit(1'b1);
    wait_idle(4 * BitCyc);
    exp_data = 8'hFF;
    g0 = pop_got();
    g1 = pop_got();
    checks += 5;
    if (dv_cnt - dv0 != 2) begin errors++; $display("FAIL b2b_dv_count got %0d want 2", dv_cnt - dv0); end
    if (g0 !== 8'h00) begin errors++; $display("FAIL b2b_first got %0h want 00", g0); end
    if (g1 !== 8'hFF) begin errors++; $display("FAIL b2b_second got %0h want ff", g1); end
    if (bus.DATA !== exp_data) begin errors++; $display("FAIL b2b_data got %0h want ff", bus.DATA); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL b2b_fe got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_sclr_abort();
    int dv0, fe0;
    logic [7:0] b, g;
    b = 8'h55;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    bus.RXD = b[3];
    repeat (BitCyc / 2) @(negedge SCLK);
    SCLR = 1'b1;
    bus.RXD = 1'b1;
    @(negedge SCLK);
    checks += 5;
    if (bus.DATA !== 8'h00) begin errors++; $display("FAIL sclr_data got %0h want 00", bus.DATA); end
    if (bus.DATA_VALID !== 1'b0) begin errors++; $display("FAIL sclr_dv got %b want 0", bus.DATA_VALID); end
    if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL sclr_fe got %b want 0", bus.FRAME_ERR); end
    if (bus.PAR_ERR !== 1'b0) begin errors++; $display("FAIL sclr_pe got %b want 0", bus.PAR_ERR); end
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL sclr_busy got %b want 0", bus.BUSY); end
    SCLR = 1'b0;
    exp_data = 8'h00;
    repeat (2 * BitCyc) @(negedge SCLK);
    checks += 2;
    if (dv_cnt != dv0) begin errors++; $display("FAIL sclr_no_dv got %0d want 0", dv_cnt - dv0); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL sclr_no_fe got %0d want 0", fe_cnt - fe0); end
    send_frame(b, good_par(b), 1'b1);
    send_bit(1'b1);
    wait_idle(4 * BitCyc);
    exp_data = b;
    g = pop_got();
    checks += 2;
    if (dv_cnt - dv0 != 1) begin errors++; $display("FAIL sclr_next_dv got %0d want 1", dv_cnt - dv0); end
    if (g !== 8'h55) begin errors++; $display("FAIL sclr_next_data got %0h want 55", g); end
  endtask

  task automatic test_parity();
    int dv0, pe0, pd0;
    logic [7:0] g;
    dv0 = dv_cnt; pe0 = pe_cnt; pd0 = pe_dv_cnt;
    // 0x07 has three ones; a 0 parity bit is wrong for even parity.
    send_frame(8'h07, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_idle(4 * BitCyc);
    exp_data = 8'h07;
    g = pop_got();
    checks += 4;
    if (dv_cnt - dv0 != 1) begin errors++; $display("FAIL par_dv got %0d want 1", dv_cnt - dv0); end
    if (g !== 8'h07) begin errors++; $display("FAIL par_data got %0h want 07", g); end
    if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL par_pe got %0d want 1", pe_cnt - pe0); end
    if (pe_dv_cnt - pd0 != 1) begin errors++; $display("FAIL par_together got %0d want 1", pe_dv_cnt - pd0); end
  endtask

  task automatic test_random();
    int dv0, fe0, pe0, exp_pe, gap;
    logic [7:0] exp_q[$];
    logic [7:0] b, g, e;
    logic par;
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    exp_pe = 0;
    for (int n = 0; n < 10; n++) begin
      b   = 8'($urandom);
      par = good_par(b) ^ (ParEn && $urandom_range(0, 1) == 1);
      exp_q.push_back(b);
      if (ParEn && (((^b) ^ par) != ParOdd[0])) exp_pe++;
      send_frame(b, par, 1'b1);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) send_bit(1'b1);
    end
    send_bit(1'b1);
    wait_idle(4 * BitCyc);
    checks += 3;
    if (dv_cnt - dv0 != 10) begin errors++; $display("FAIL rand_dv_count got %0d want 10", dv_cnt - dv0); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL rand_fe got %0d want 0", fe_cnt - fe0); end
    if (pe_cnt - pe0 != exp_pe) begin errors++; $display("FAIL rand_pe got %0d want %0d", pe_cnt - pe0, exp_pe); end
    for (int n = 0; n < 10; n++) begin
      e = exp_q.pop_front();
      g = pop_got();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rand_data[%0d] got %0h want %0h", n, g, e); end
    end
    exp_data = e;
    checks += 2;
    if (bus.DATA !== exp_data) begin errors++; $display("FAIL rand_last_data got %0h want %0h", bus.DATA, exp_data); end
    if (both_cnt != 0) begin errors++; $display("FAIL dv_fe_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    SCLR = 1'b1;
    bus.RXD = 1'b1;
    @(negedge SCLK);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_sclr_abort();
    if (ParEn) test_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "bench timed out");
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving BAUD_CLK ticks per bit; legal values are even and at least 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range is 5..8.
REQ-003 SHALL have parameter PARITY_ODD, default 0, selecting odd parity when 1 and even parity when 0; it is used only when UART_RX_PARITY_EN is defined.
REQ-004 Port SCLK, input, 1 bit: system clock; the block has one clock, and all logic is rising-edge SCLK.
REQ-005 Port SCLR, input, 1 bit: synchronous, active-high reset.
REQ-006 Port BAUD_CLK, input, 1 bit: oversample tick from baud_gen, one SCLK cycle wide, OVERSAMPLE ticks per bit.
REQ-007 Port RXD, input, 1 bit: asynchronous serial line; it idles high.
REQ-008 Port DATA, output, 8 bits: last good byte, LSB-aligned, with unused upper bits at 0.
REQ-009 Port DATA_VALID, output, 1 bit: one-cycle pulse that marks a new DATA value.
REQ-010 Port FRAME_ERR, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-011 Port PAR_ERR, output, 1 bit: one-cycle pulse on parity mismatch.
REQ-012 Port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 RXD SHALL pass through a 2-flop synchronizer, reset to 1, giving rxd_s; only rxd_s feeds the FSM.
REQ-014 The sample counter (sctr) and the bit counter (bctr) SHALL advance only in cycles where BAUD_CLK=1; all other cycles hold state.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-016 IDLE: on a BAUD_CLK tick with rxd_s=0, go to START with sctr=0.
REQ-017 START: at the tick where sctr reaches OVERSAMPLE/2-1 (mid-bit), the action depends on rxd_s.
  - rxd_s=0: go to DATA with sctr=0 and bctr=0.
  - rxd_s=1: treat as a glitch and return to IDLE with no output pulse.
REQ-018 DATA: at every tick where sctr reaches OVERSAMPLE-1, sample rxd_s into the shift register LSB-first and increment bctr.
  - After DATA_BITS samples, go to PARITY if UART_RX_PARITY_EN is defined, otherwise to STOP.
REQ-019 PARITY: sample one bit at mid-bit spacing (sctr=OVERSAMPLE-1) and record any mismatch, then go to STOP.
REQ-020 STOP: sample at sctr=OVERSAMPLE-1; the action depends on the sampled bit.
  - rxd_s=1: load DATA, pulse DATA_VALID (plus PAR_ERR if a mismatch was recorded), and go to IDLE.
  - rxd_s=0: pulse FRAME_ERR, leave DATA unchanged, and go to BREAK.
REQ-021 BREAK SHALL hold until a tick with rxd_s=1, then go to IDLE; a line held low SHALL NOT retrigger reception.
REQ-022 Output pulses SHALL be registered and assert in the SCLK cycle after the deciding BAUD_CLK tick, for exactly one cycle.
REQ-023 FRAME_ERR and DATA_VALID SHALL never assert in the same cycle.
REQ-024 On a parity error with a good stop bit, DATA SHALL still load, and DATA_VALID and PAR_ERR SHALL pulse together.
REQ-025 sctr SHALL wrap to 0 at OVERSAMPLE-1 within DATA, PARITY and STOP.
REQ-026 Total latency from the start-bit falling edge to DATA_VALID SHALL be (1.5+DATA_BITS[+1]) bit times, plus the synchronizer delay and up to 1 tick.

Reset
REQ-027 SCLR=1 SHALL set the state to IDLE and clear sctr, bctr and the shift register, with synchronizer flops set to 1.
  - Outputs SHALL reset to DATA=0, DATA_VALID=0, FRAME_ERR=0, PAR_ERR=0, BUSY=0.
REQ-028 SCLR mid-frame SHALL abort the frame with no output pulse; the next complete frame after release SHALL be received correctly.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, the frame SHALL include one parity bit after the data, checked per PARITY_ODD.
REQ-030 With UART_RX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent, and PAR_ERR SHALL be tied to 0.

Verification
REQ-031 Frame 0xA5 (8N1, BAUD_CLK every 4 SCLK) -> DATA=0xA5, one-cycle DATA_VALID, BUSY low afterwards, no error pulses.
REQ-032 RXD low for 4 ticks, then high -> no pulses, return to IDLE, and the following 0x3C frame is received correctly.
REQ-033 Frame 0x81 with stop bit 0, line held low for 40 ticks -> single FRAME_ERR pulse, DATA keeps its previous value, BUSY high until RXD rises.
REQ-034 Frames 0x00 and 0xFF sent back-to-back (stop bit followed immediately by start) -> two DATA_VALID pulses with DATA 0x00 then 0xFF.
REQ-035 SCLR pulsed during bit 3 of 0x55 -> all outputs 0 and no pulse; the next frame 0x55 gives DATA=0x55.
REQ-036 With UART_RX_PARITY_EN defined and even parity, 0x07 sent with parity bit 0 -> DATA=0x07, DATA_VALID and PAR_ERR pulse together.
